// File: rtl/if_stage.sv
// Instruction-fetch stage and IF/ID pipeline register.
// Owns the PC, fetches over a req/ack instruction-memory handshake and
// delivers pc4/inst/inst_valid to decode. Branches use a MIPS-style delay slot.
// Optional build macro IF_BRANCH_SQUASH_EN: when defined, the delay-slot
// instruction of a taken branch/jump enters decode as a bubble.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        stall,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] jpc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc4,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic        if_busy
);

    typedef enum logic {
        S_FETCH = 1'b0,
        S_HOLD  = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [31:0] r_pc;
    logic [31:0] r_redir_pc;
    logic        r_redir_valid;
    logic [31:0] r_buf_inst;
    logic [31:0] r_pc4;
    logic [31:0] r_inst;
    logic        r_inst_valid;

    logic        w_take;
    logic        w_fetch_ack;
    logic        w_have;
    logic        w_taken;
    logic        w_squash;
    logic [31:0] w_word;
    logic [31:0] w_target;
    logic [31:0] w_pc_plus4;

    // Decode consumes IF/ID whenever it is not stalled.
    assign w_take      = ~stall;
    // An ack only counts while a request is actually on the bus.
    assign w_fetch_ack = (r_state == S_FETCH) & imem_ack;
    assign w_have      = w_fetch_ack | (r_state == S_HOLD);
    assign w_word      = (r_state == S_HOLD) ? r_buf_inst : imem_rdata;
    assign w_pc_plus4  = r_pc + 32'd4;

    // Redirects are only honoured for a real instruction that decode is consuming.
    assign w_taken  = w_take & r_inst_valid & ((pcsource == 2'b01) | (pcsource == 2'b10));
    assign w_target = (pcsource == 2'b10) ? jpc : bpc;

`ifdef IF_BRANCH_SQUASH_EN
    // The word captured alongside a taken redirect, or the delay-slot fetch
    // that a pending redirect is waiting on, is the delay slot: annul it.
    assign w_squash = w_taken | r_redir_valid;
`else
    assign w_squash = 1'b0;
`endif

    // Request is held low during reset so a stale transaction is never reissued.
    assign imem_req   = clrn & (r_state == S_FETCH);
    assign imem_addr  = r_pc;
    assign if_busy    = imem_req & ~imem_ack;
    assign pc4        = r_pc4;
    assign inst       = r_inst;
    assign inst_valid = r_inst_valid;

    // FSM state register.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: park a fetched word while decode is stalled, resume on take.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_FETCH: if (imem_ack && !w_take) w_state_nxt = S_HOLD;
            S_HOLD:  if (w_take)              w_state_nxt = S_FETCH;
            default: w_state_nxt = S_FETCH;
        endcase
    end

    // PC and pending-redirect flag; PC only moves when a word is handed to decode.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_pc          <= RESET_PC;
            r_redir_valid <= 1'b0;
        end else if (w_take && w_have) begin
            r_pc          <= w_taken ? w_target : (r_redir_valid ? r_redir_pc : w_pc_plus4);
            r_redir_valid <= 1'b0;
        end else if (w_taken) begin
            r_redir_valid <= 1'b1;
        end
    end

    // Redirect target captured when the delay-slot fetch is still in flight.
    always_ff @(posedge clk) begin
        if (w_taken && !w_have) begin
            r_redir_pc <= w_target;
        end
    end

    // Buffer for a word that arrived while decode was stalled.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_buf_inst <= 32'd0;
        end else if (w_fetch_ack && !w_take) begin
            r_buf_inst <= imem_rdata;
        end
    end

    // IF/ID register: load a word, insert a bubble, or hold under stall.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_pc4        <= RESET_PC;
            r_inst       <= NOP_INST;
            r_inst_valid <= 1'b0;
        end else if (w_take) begin
            if (w_have) begin
                r_pc4        <= w_pc_plus4;
                r_inst       <= w_squash ? NOP_INST : w_word;
                r_inst_valid <= ~w_squash;
            end else begin
                r_inst       <= NOP_INST;
                r_inst_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: randomized memory latency, decode stalls
// and branch/jump redirects, checked against a program-order fetch model.
module tb_if_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INST = 32'h0BAD_0013;
    localparam int          DEPTH    = 8192;

    logic        clk = 1'b0;
    logic        clrn;
    logic        stall;
    logic [1:0]  pcsource;
    logic [31:0] bpc;
    logic [31:0] jpc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc4;
    logic [31:0] inst;
    logic        inst_valid;
    logic        if_busy;

    if_stage #(
        .RESET_PC(RESET_PC),
        .NOP_INST(NOP_INST)
    ) dut (
        .clk       (clk),
        .clrn      (clrn),
        .stall     (stall),
        .pcsource  (pcsource),
        .bpc       (bpc),
        .jpc       (jpc),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_rdata(imem_rdata),
        .pc4       (pc4),
        .inst      (inst),
        .inst_valid(inst_valid),
        .if_busy   (if_busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Program-order model: exp_f[k] is the address of the k-th fetch.
    logic [31:0] exp_f [0:DEPTH-1];
    bit          ovr   [0:DEPTH-1];
    bit          sq    [0:DEPTH-1];
    int          f;
    int          d;
    int          wait_cnt;
    bit          parked;
    bit          p_wait;
    bit          p_hold;
    bit          p_bubble;
    bit          p_fill;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] pick_target();
        int unsigned sel;
        sel = $urandom_range(7, 0);
        if (sel == 0) return 32'hFFFF_FFF8;
        if (sel == 1) return 32'hFFFF_FFFC;
        return 32'($urandom_range(4095, 0)) << 2;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            ovr[i] = 1'b0;
            sq[i]  = 1'b0;
        end
        exp_f[0] = RESET_PC;
        f        = 0;
        d        = 0;
        wait_cnt = 0;
        parked   = 1'b0;
        p_wait   = 1'b0;
        p_hold   = 1'b0;
        p_bubble = 1'b0;
        p_fill   = 1'b0;
    endtask

    task automatic reset_checks(input string pfx);
        check({pfx, "_pc4"},   pc4, RESET_PC);
        check({pfx, "_inst"},  inst, NOP_INST);
        check({pfx, "_valid"}, 32'(inst_valid), 32'd0);
        check({pfx, "_req"},   32'(imem_req), 32'd0);
        check({pfx, "_busy"},  32'(if_busy), 32'd0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        clrn     = 1'b1;
        imem_ack = 1'b0;
        stall    = 1'b0;
        pcsource = 2'b00;
        model_reset();
        #1;
        check("rel_req",  32'(imem_req), 32'd1);
        check("rel_addr", imem_addr, RESET_PC);
    endtask

    // One clock of memory, decode and checking, all done at the falling edge.
    task automatic step(input int minlat, input int maxlat, input int stall_pct, input int br_pct);
        logic [31:0] tgt;
        @(negedge clk);
        if (imem_req && wait_cnt == 0) begin
            imem_ack   = 1'b1;
            imem_rdata = mem_word(imem_addr);
        end else begin
            imem_ack   = 1'b0;
            imem_rdata = $urandom;
            if (imem_req) wait_cnt--;
        end
        stall = ($urandom_range(99, 0) < stall_pct);

        if (p_wait)   check("wait_req", 32'(imem_req), 32'd1);
        if (p_hold)   check("hold_req", 32'(imem_req), 32'd0);
        if (p_bubble) check("bubble_valid", 32'(inst_valid), 32'd0);
`ifndef IF_BRANCH_SQUASH_EN
        if (p_fill)   check("fill_valid", 32'(inst_valid), 32'd1);
`endif
        if (imem_req) check("imem_addr", imem_addr, exp_f[f]);
        if (inst_valid) begin
            while (sq[d]) d++;
            check("inst", inst, mem_word(exp_f[d]));
            check("pc4", pc4, exp_f[d] + 32'd4);
        end else begin
            check("bubble_inst", inst, NOP_INST);
        end

        bpc = $urandom;
        jpc = $urandom;
        if (inst_valid && !stall) begin
            if ($urandom_range(99, 0) < br_pct) begin
                tgt = pick_target();
                if ($urandom_range(1, 0) == 1) begin
                    pcsource = 2'b10;
                    jpc      = tgt;
                end else begin
                    pcsource = 2'b01;
                    bpc      = tgt;
                end
                exp_f[d+2] = tgt;
                ovr[d+2]   = 1'b1;
`ifdef IF_BRANCH_SQUASH_EN
                sq[d+1]    = 1'b1;
`endif
            end else begin
                pcsource = ($urandom_range(1, 0) == 1) ? 2'b11 : 2'b00;
            end
            d++;
        end else begin
            pcsource = 2'($urandom_range(3, 0));
        end

        #1;
        check("if_busy", 32'(if_busy), 32'(imem_req & ~imem_ack));
        if (imem_req && imem_ack) begin
            if (!ovr[f+1]) exp_f[f+1] = exp_f[f] + 32'd4;
            f++;
            wait_cnt = int'($urandom_range(maxlat, minlat));
        end
        p_wait   = imem_req & ~imem_ack;
        p_hold   = imem_req & imem_ack & stall;
        p_bubble = imem_req & ~imem_ack & ~stall;
        p_fill   = ((imem_req & imem_ack) | parked) & ~stall;
        if (imem_req && imem_ack && stall) parked = 1'b1;
        else if (!stall)                   parked = 1'b0;
    endtask

    initial begin
        clrn       = 1'b0;
        stall      = 1'b0;
        pcsource   = 2'b00;
        bpc        = 32'd0;
        jpc        = 32'd0;
        imem_ack   = 1'b1;
        imem_rdata = 32'hBAD0_BAD0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        reset_checks("rst");
        release_reset();

        for (int i = 0; i < 12; i++) begin
            step(0, 0, 0, 0);
            check("zw_req", 32'(imem_req), 32'd1);
        end
        for (int i = 0; i < 40; i++)   step(2, 2, 0, 0);
        for (int i = 0; i < 80; i++)   step(0, 3, 40, 0);
        for (int i = 0; i < 2000; i++) step(0, 3, 25, 15);

        // Reset in the middle of a slow fetch, with a late ack during reset.
        for (int i = 0; i < 20 && !p_wait; i++) step(3, 3, 0, 0);
        check("mf_reach", 32'(p_wait), 32'd1);
        @(negedge clk);
        clrn       = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'hCAFE_F00D;
        stall      = 1'b0;
        #1;
        reset_checks("mf");
        repeat (2) @(negedge clk);
        #1;
        reset_checks("mf_hold");
        release_reset();
        for (int i = 0; i < 300; i++) step(0, 2, 20, 15);

        check("drain", 32'((f - d) <= 2), 32'd1);
        check("progress", 32'(d > 100), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register of the 5-stage pipeline.
- Owns the PC and fetches from an instruction memory over a req/ack handshake, so memory latency may vary.
- Delivers pc4/inst to the decode stage and accepts stall, pcsource, bpc and jpc back from decode.
- Branch semantics are MIPS-style delayed branch: the instruction after a branch always executes.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INST, 32'h0000_0000, encoding driven on inst when the IF/ID slot holds a bubble.

Ports:
- clk  in  1  clock, rising edge.
- clrn  in  1  asynchronous active-low reset.
- stall  in  1  decode load-use stall; 1 = decode does not accept a new instruction this cycle.
- pcsource  in  2  00 seq, 01 branch (bpc), 10 jump (jpc), 11 treated as 00.
- bpc  in  32  branch target from decode.
- jpc  in  32  jump target from decode.
- imem_req  out  1  fetch request; held until ack.
- imem_addr  out  32  fetch address (= PC); stable while imem_req=1.
- imem_ack  in  1  read data valid; may assert in the same cycle as req (zero wait).
- imem_rdata  in  32  instruction word, sampled when req & ack.
- pc4  out  32  IF/ID: fetch address + 4.
- inst  out  32  IF/ID: instruction word, or NOP_INST when the slot is a bubble.
- inst_valid  out  1  IF/ID slot holds a real instruction.
- if_busy  out  1  fetch outstanding (imem_req & ~imem_ack).

Behaviour:
- Reset (async, clrn=0):
  - pc=RESET_PC; FSM=FETCH; redir_valid=0; buf_inst=0.
  - pc4=RESET_PC; inst=NOP_INST; inst_valid=0.
  - imem_req forced 0 while clrn=0 and first asserts in the first cycle after release.
- Reset mid-fetch: the outstanding request is abandoned, and any ack arriving during reset is ignored.
- FSM states:
  - FETCH: imem_req=1, imem_addr=pc.
  - HOLD: imem_req=0; fetched word parked in buf_inst.
- Definitions:
  - take = ~stall, meaning decode consumes IF/ID at this edge.
  - have = (FETCH & imem_ack) | HOLD.
  - word = HOLD ? buf_inst : imem_rdata.
- Transitions:
  - FETCH & ack & take -> FETCH; PC advances and the next request goes out the next cycle.
  - FETCH & ack & ~take -> HOLD; buf_inst <= imem_rdata.
  - HOLD & take -> FETCH.
  - FETCH & ~ack, and HOLD & ~take -> stay.
- IF/ID update:
  - take & have: pc4 <= pc+4, inst <= word, inst_valid <= 1.
  - take & ~have: bubble; inst <= NOP_INST, inst_valid <= 0, pc4 unchanged.
  - ~take: IF/ID holds all fields.
- Redirect:
  - taken = take & inst_valid & (pcsource==01 | pcsource==10).
  - target = bpc for 01, jpc for 10.
  - pcsource is ignored when stall=1 or inst_valid=0.
- PC update, only on take & have:
  - pc <= taken ? target : redir_valid ? redir_pc : pc+4.
  - redir_valid <= 0.
- Pending redirect: when taken & ~have, set redir_valid <= 1 and redir_pc <= target. The delay-slot fetch still in flight completes at the old address, then PC jumps to redir_pc.
- taken with redir_valid=1 cannot occur, because a pending redirect implies a bubble is in decode; no priority rule is needed.
- pc+4 wraps modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
- imem_addr must not change while imem_req=1 & ~imem_ack.

Optional Feature:
- Macro: IF_BRANCH_SQUASH_EN.
- Defined: the delay slot is annulled. When taken, the instruction captured into IF/ID at that edge (or the pending delay-slot fetch, if taken & ~have) enters decode with inst=NOP_INST and inst_valid=0. Its fetch still completes on the bus.
- Undefined: delayed-branch behaviour exactly as above.

Test Plan:
- Reset then zero-wait memory (ack tied to req), pcsource=00, stall=0 -> imem_addr 0,4,8,... on consecutive cycles; inst_valid=1 from the second cycle; pc4 = 4,8,12.
- Memory with 2-cycle ack latency -> one bubble per fetch (inst_valid=0, inst=NOP_INST); if_busy=1 during waits; imem_addr stable while waiting.
- stall=1 for 3 cycles while ack arrives -> FSM enters HOLD, imem_req=0, IF/ID unchanged; after stall drops, the buffered word appears with the correct pc4 and fetch resumes at next address.
- Branch at 0x10, pcsource=01, bpc=0x40, zero-wait -> delay slot 0x14 enters decode; next imem_addr=0x40. With IF_BRANCH_SQUASH_EN the 0x14 slot has inst_valid=0.
- Jump with delay-slot fetch still outstanding (jpc=0x100) -> redir_valid set; after the slot's ack the next address is 0x100, not slot+4.
- clrn pulsed low mid-fetch with a late ack -> all outputs at reset values; first request after release is at RESET_PC; the stale ack is ignored.
